cmac_column_sequencer: RTL and testbench
========================================

Name: cmac_column_sequencer

Overview:
- Sequences one systolic column of N_STAGES chained CMAC_unit_default error-compensation MAC stages.
- Loads the per-stage weights, streams skewed activation vectors into the column and injects the initial partial sum at stage 0.
- At the column tail, adds the accumulated error product to the final partial sum and returns the compensated result over a valid/ready port.
- Counts timing-error events reported by the stages. Sits between the accelerator's tile scheduler and the column datapath.

Parameters:
N_STAGES, 2, number of chained MAC stages in the column
DATA_W, 8, weight/activation width
PSUM_W, 24, partial-sum width
ERR_W, 16, error-product width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
start  in  1  job request, sampled in IDLE only
vec_len  in  8  activation vectors in the job, 1..255
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when the last result has been issued
w_valid  in  1  weight beat valid
w_ready  out  1  high in LOAD
w_data  in  N_STAGES*DATA_W  weights, stage k in bits [k*DATA_W +: DATA_W]
a_valid  in  1  activation vector valid
a_ready  out  1  activation accept
a_data  in  N_STAGES*DATA_W  activation vector, element k is for stage k
psum_init  in  PSUM_W  initial partial sum for each vector
weight_bus  out  N_STAGES*DATA_W  registered weights to the stages
weight_load  out  1  one-cycle weight capture strobe
act_bus  out  N_STAGES*DATA_W  skewed activations to the stages
psum_inj  out  PSUM_W  partial sum into stage 0
err_inj  out  ERR_W  error product into stage 0, constant 0
array_en  out  1  column clock enable
psum_col  in  PSUM_W  partial_sum_out of the last stage
err_col  in  ERR_W  error_product_out of the last stage
err_sig_col  in  N_STAGES  error_sig of each stage
r_valid  out  1  result valid
r_ready  in  1  result accept
r_data  out  PSUM_W  compensated result
err_count  out  16  error events in the current or last job

Behaviour:
- Reset (async, any state, including mid-job):
  - state IDLE.
  - All outputs 0, including weight_bus, act_bus, skew registers, in-flight pipe and counters.
- array_en = !(r_valid && !r_ready). The array, skew registers and in-flight pipe advance only when array_en=1.
- States:
  - IDLE: start=1 with vec_len!=0 -> LOAD; clears err_count and issue count, latches vec_len. start with vec_len=0 is ignored. start outside IDLE is ignored.
  - LOAD: w_ready=1. On w_valid: capture w_data into weight_bus, pulse weight_load for 1 cycle, go to STREAM.
  - STREAM:
    - a_ready = array_en.
    - Accept (a_valid && a_ready): element 0 is driven onto act_bus slot 0 the next cycle; element k passes through k skew registers; psum_inj = psum_init; a valid bit enters the in-flight pipe (length N_STAGES); issue count increments.
    - No accept while array_en=1: zeros/bubble are driven, valid bit 0 enters the pipe.
    - When issue count reaches vec_len: go to DRAIN; a_ready=0 from that cycle.
  - DRAIN: bubbles continue until the in-flight pipe and skew registers are empty and r_valid has been accepted, then pulse done and go to IDLE.
- Result path:
  - Latency from accept to r_valid is N_STAGES+1 cycles with array_en held high.
  - When the pipe tail is 1 and array_en=1: r_data <= psum_col + zero-extend(err_col), wrapping mod 2^PSUM_W, and r_valid <= 1.
  - r_valid clears on r_ready unless a new result loads in the same cycle.
- err_count: +1 on each cycle with array_en=1, |err_sig_col, and any in-flight bit set. Saturates at 0xFFFF. Holds after done until the next start.
- Backpressure: with r_ready=0 and r_valid=1 the whole column freezes and no result is lost or duplicated.

Test Plan:
- N_STAGES=2, vec_len=1, weights {0x30,0x10}, a_data {0x04,0x02}, psum_init=0x4000; bench column model with err_col=0 -> r_data=0x0040E0 exactly 3 cycles after accept, then done 1 cycle later, err_count=0.
- Same job with err_col=0x12 and err_sig_col=2'b10 for one cycle -> r_data=0x0040F2, err_count=1.
- vec_len=4, a_valid toggling every other cycle -> exactly 4 results in order, 4 a_ready handshakes, done once.
- r_ready held 0 for 5 cycles mid-stream -> array_en=0, a_ready=0, r_data stable; all results delivered after release.
- rst asserted during STREAM -> all outputs 0 immediately, state IDLE; a new start then behaves like the first scenario.
- start with vec_len=0, and start while busy -> no state change, busy unchanged.

Source files
------------

// File: rtl/cmac_column_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : cmac_column_sequencer_if
//  Description : Job, weight, activation, column and result signals between
//                the tile scheduler / column datapath and the column sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cmac_column_sequencer_if #(
    parameter int N_STAGES = 2,
    parameter int DATA_W   = 8,
    parameter int PSUM_W   = 24,
    parameter int ERR_W    = 16
);
    // Job control
    logic                         start;
    logic [7:0]                   vec_len;
    logic                         busy;
    logic                         done;
    // Weight load
    logic                         w_valid;
    logic                         w_ready;
    logic [N_STAGES*DATA_W-1:0]   w_data;
    // Activation stream
    logic                         a_valid;
    logic                         a_ready;
    logic [N_STAGES*DATA_W-1:0]   a_data;
    logic [PSUM_W-1:0]            psum_init;
    // Column datapath
    logic [N_STAGES*DATA_W-1:0]   weight_bus;
    logic                         weight_load;
    logic [N_STAGES*DATA_W-1:0]   act_bus;
    logic [PSUM_W-1:0]            psum_inj;
    logic [ERR_W-1:0]             err_inj;
    logic                         array_en;
    logic [PSUM_W-1:0]            psum_col;
    logic [ERR_W-1:0]             err_col;
    logic [N_STAGES-1:0]          err_sig_col;
    // Result
    logic                         r_valid;
    logic                         r_ready;
    logic [PSUM_W-1:0]            r_data;
    logic [15:0]                  err_count;

    // Scheduler / column side
    modport master (
        output start, vec_len, w_valid, w_data, a_valid, a_data, psum_init,
               psum_col, err_col, err_sig_col, r_ready,
        input  busy, done, w_ready, a_ready, weight_bus, weight_load, act_bus,
               psum_inj, err_inj, array_en, r_valid, r_data, err_count
    );

    // Sequencer side
    modport slave (
        input  start, vec_len, w_valid, w_data, a_valid, a_data, psum_init,
               psum_col, err_col, err_sig_col, r_ready,
        output busy, done, w_ready, a_ready, weight_bus, weight_load, act_bus,
               psum_inj, err_inj, array_en, r_valid, r_data, err_count
    );
endinterface
`default_nettype wire

// File: rtl/cmac_column_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cmac_column_sequencer
//  Description : Sequences one systolic column of chained error-compensating
//                MAC stages: weight load, skewed activation streaming, tail
//                error compensation, result handshake and error counting.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmac_column_sequencer #(
    parameter int N_STAGES = 2,
    parameter int DATA_W   = 8,
    parameter int PSUM_W   = 24,
    parameter int ERR_W    = 16
) (
    input  wire logic               clk,
    input  wire logic               rst,
    cmac_column_sequencer_if.slave  seq_if
);
    localparam int          VW        = N_STAGES * DATA_W;
    localparam logic [1:0]  S_IDLE    = 2'd0;
    localparam logic [1:0]  S_LOAD    = 2'd1;
    localparam logic [1:0]  S_STREAM  = 2'd2;
    localparam logic [1:0]  S_DRAIN   = 2'd3;
    localparam logic [15:0] C_ERR_MAX = 16'hFFFF;

    logic [1:0]          state_q, state_d;
    logic [7:0]          vec_len_q;
    logic [7:0]          issue_cnt_q;
    logic [VW-1:0]       weight_q;
    logic                weight_load_q;
    logic [PSUM_W-1:0]   psum_inj_q;
    logic [N_STAGES-1:0] inflight_q;
    logic                r_valid_q;
    logic [PSUM_W-1:0]   r_data_q;
    logic [15:0]         err_count_q;

    logic w_array_en, w_job_start, w_accept, w_last_issue, w_drain_empty;
    logic w_busy, w_w_ready, w_a_ready, w_done;
    wire  [VW-1:0] w_act_bus;

    // The whole column stalls only while a result is waiting to be taken
    assign w_array_en    = !(r_valid_q && !seq_if.r_ready);
    assign w_job_start   = (state_q == S_IDLE) && seq_if.start && (seq_if.vec_len != 8'd0);
    assign w_accept      = (state_q == S_STREAM) && seq_if.a_valid && w_array_en;
    assign w_last_issue  = (issue_cnt_q + 8'd1) == vec_len_q;
    // Skew lanes are never deeper than the in-flight pipe, so an empty pipe
    // also means the skew registers hold only bubbles
    assign w_drain_empty = (inflight_q == '0) && !r_valid_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (w_job_start)                 state_d = S_LOAD;
            S_LOAD:   if (seq_if.w_valid)              state_d = S_STREAM;
            S_STREAM: if (w_accept && w_last_issue)    state_d = S_DRAIN;
            S_DRAIN:  if (w_drain_empty)               state_d = S_IDLE;
            default:                                   state_d = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_busy    = (state_q != S_IDLE);
        w_w_ready = (state_q == S_LOAD);
        w_a_ready = (state_q == S_STREAM) && w_array_en;
        w_done    = (state_q == S_DRAIN) && w_drain_empty;
    end

    // Job length, issue count, weight capture and error-event counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_len_q     <= '0;
            issue_cnt_q   <= '0;
            weight_q      <= '0;
            weight_load_q <= 1'b0;
            err_count_q   <= '0;
        end else begin
            weight_load_q <= 1'b0;
            if (w_job_start) begin
                vec_len_q   <= seq_if.vec_len;
                issue_cnt_q <= '0;
            end else if (w_accept) begin
                issue_cnt_q <= issue_cnt_q + 8'd1;
            end
            if (w_w_ready && seq_if.w_valid) begin
                weight_q      <= seq_if.w_data;
                weight_load_q <= 1'b1;
            end
            if (w_job_start) begin
                err_count_q <= '0;
            end else if (w_array_en && (|seq_if.err_sig_col) && (|inflight_q)
                         && (err_count_q != C_ERR_MAX)) begin
                err_count_q <= err_count_q + 16'd1;
            end
        end
    end

    // Stage-0 partial-sum injection and in-flight markers advance with the column
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psum_inj_q <= '0;
            inflight_q <= '0;
        end else if (w_array_en) begin
            psum_inj_q    <= w_accept ? seq_if.psum_init : '0;
            inflight_q[0] <= w_accept;
            for (int i = 1; i < N_STAGES; i++) begin
                inflight_q[i] <= inflight_q[i-1];
            end
        end
    end

    // Tail result register: compensate the final partial sum with the error product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else if (w_array_en && inflight_q[N_STAGES-1]) begin
            r_valid_q <= 1'b1;
            r_data_q  <= seq_if.psum_col + PSUM_W'(seq_if.err_col);
        end else if (seq_if.r_ready) begin
            r_valid_q <= 1'b0;
        end
    end

    // Activation lanes: lane k reaches its stage k cycles after lane 0
    generate
        for (genvar k = 0; k < N_STAGES; k++) begin : g_lane
            logic [DATA_W-1:0] w_elem;
            logic [DATA_W-1:0] lane_q;

            assign w_elem = w_accept ? seq_if.a_data[k*DATA_W +: DATA_W] : '0;

            if (k == 0) begin : g_direct
                // Lane 0 drives its stage directly
                always_ff @(posedge clk or posedge rst) begin
                    if (rst)             lane_q <= '0;
                    else if (w_array_en) lane_q <= w_elem;
                end
            end else begin : g_skewed
                logic [DATA_W-1:0] skew_q [k];
                // Lane k passes through k skew registers before its stage
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        for (int j = 0; j < k; j++) skew_q[j] <= '0;
                        lane_q <= '0;
                    end else if (w_array_en) begin
                        skew_q[0] <= w_elem;
                        for (int j = 1; j < k; j++) skew_q[j] <= skew_q[j-1];
                        lane_q <= skew_q[k-1];
                    end
                end
            end

            assign w_act_bus[k*DATA_W +: DATA_W] = lane_q;
        end
    endgenerate

    assign seq_if.busy        = w_busy;
    assign seq_if.done        = w_done;
    assign seq_if.w_ready     = w_w_ready;
    assign seq_if.a_ready     = w_a_ready;
    assign seq_if.weight_bus  = weight_q;
    assign seq_if.weight_load = weight_load_q;
    assign seq_if.act_bus     = w_act_bus;
    assign seq_if.psum_inj    = psum_inj_q;
    assign seq_if.err_inj     = '0;
    assign seq_if.array_en    = w_array_en;
    assign seq_if.r_valid     = r_valid_q;
    assign seq_if.r_data      = r_data_q;
    assign seq_if.err_count   = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_cmac_column_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmac_column_sequencer
//  Description : Self-checking bench for cmac_column_sequencer with a simple
//                two-stage column model and a result scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmac_column_sequencer;
    localparam int N  = 2;
    localparam int DW = 8;
    localparam int PW = 24;
    localparam int EW = 16;

    typedef struct {
        logic [7:0]  w0, w1, a0, a1;
        logic [23:0] psum;
        logic [15:0] err;
        bit          pulse;
        logic [23:0] exp_r;
        logic [15:0] exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cmac_column_sequencer_if #(.N_STAGES(N), .DATA_W(DW), .PSUM_W(PW), .ERR_W(EW)) bus ();

    cmac_column_sequencer #(.N_STAGES(N), .DATA_W(DW), .PSUM_W(PW), .ERR_W(EW)) dut (
        .clk    (clk),
        .rst    (rst),
        .seq_if (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          res_cnt = 0;
    int          done_cnt = 0;
    bit          mon_en = 0;
    logic [15:0] cur_w = '0;
    logic [23:0] sb [$];
    vec_t        tab [5];

    // Column stand-in: stage 0 registered, last stage adds its product at the output
    logic [23:0] col_p0;
    always @(posedge clk or posedge rst) begin
        if (rst) col_p0 <= '0;
        else if (bus.array_en)
            col_p0 <= bus.psum_inj + {16'd0, bus.weight_bus[7:0]} * {16'd0, bus.act_bus[7:0]};
    end
    always_comb begin
        bus.psum_col = col_p0 + {16'd0, bus.weight_bus[15:8]} * {16'd0, bus.act_bus[15:8]};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected compensated result: psum + sum of weight*activation + error, mod 2^24
    function automatic logic [23:0] ref_result(input logic [15:0] w, input logic [15:0] a,
                                               input logic [23:0] p, input logic [15:0] e);
        logic [31:0] acc;
        acc = {8'd0, p} + {16'd0, e};
        for (int k = 0; k < N; k++)
            acc = acc + {24'd0, w[k*8 +: 8]} * {24'd0, a[k*8 +: 8]};
        return acc[23:0];
    endfunction

    // Scoreboard: enqueue on activation handshake, compare on result handshake
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (bus.a_valid && bus.a_ready)
                sb.push_back(ref_result(cur_w, bus.a_data, bus.psum_init, bus.err_col));
            if (bus.r_valid && bus.r_ready) begin
                res_cnt++;
                if (sb.size() == 0) chk("unexpected_result", bus.r_data, 0);
                else                chk("result_data", bus.r_data, sb.pop_front());
            end
            if (bus.done) done_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic start_job(input logic [7:0] len);
        bus.start = 1'b1; bus.vec_len = len;
        step();
        bus.start = 1'b0;
    endtask

    task automatic load_w(input logic [15:0] w);
        bus.w_valid = 1'b1; bus.w_data = w; cur_w = w;
        step();
        bus.w_valid = 1'b0;
        chk("weight_load", bus.weight_load, 1);
        chk("weight_bus", bus.weight_bus, w);
    endtask

    task automatic run_single(input vec_t v);
        int lat;
        bus.err_col = v.err; bus.r_ready = 1'b1;
        start_job(8'd1);
        load_w({v.w1, v.w0});
        bus.a_valid = 1'b1; bus.a_data = {v.a1, v.a0}; bus.psum_init = v.psum;
        step();
        bus.a_valid = 1'b0;
        bus.err_sig_col = v.pulse ? 2'b10 : 2'b00;
        lat = 1;
        while (!bus.r_valid && lat < 20) begin
            step();
            bus.err_sig_col = 2'b00;
            lat++;
        end
        bus.err_sig_col = 2'b00;
        chk("latency", lat, 3);
        chk("r_data", bus.r_data, v.exp_r);
        step();
        chk("done_pulse", {bus.done, bus.r_valid}, 2'b10);
        step();
        chk("idle_after_done", {bus.busy, bus.done}, 2'b00);
        chk("err_count", bus.err_count, v.exp_cnt);
    endtask

    task automatic run_job(input int len, input bit toggle, input int stall_len,
                           input int avp, input int rrp);
        int sent, cyc, res0, done0, stall_left;
        bit stall_used, finished, prev_hold;
        logic [23:0] prev_data;
        sent = 0; cyc = 0; stall_left = 0; stall_used = 0; finished = 0; prev_hold = 0;
        prev_data = '0;
        res0 = res_cnt; done0 = done_cnt;
        bus.err_col = 16'($urandom); bus.r_ready = 1'b1;
        start_job(8'(len));
        load_w(16'($urandom));
        while (!finished && cyc < 400) begin
            bus.a_valid   = (sent < len) && (toggle ? (cyc % 2 == 0) : ($urandom_range(0, 99) < avp));
            bus.a_data    = 16'($urandom);
            bus.psum_init = 24'($urandom);
            if (stall_len > 0 && !stall_used && bus.r_valid) begin
                stall_used = 1; stall_left = stall_len;
            end
            if (stall_left > 0) begin
                bus.r_ready = 1'b0; stall_left--;
            end else begin
                bus.r_ready = (stall_len > 0 || toggle) ? 1'b1 : ($urandom_range(0, 99) < rrp);
            end
            @(negedge clk);
            if (prev_hold) begin
                chk("hold_valid", bus.r_valid, 1);
                chk("hold_data", bus.r_data, prev_data);
            end
            if (bus.r_valid && !bus.r_ready) begin
                chk("freeze_array_en", bus.array_en, 0);
                chk("freeze_a_ready", bus.a_ready, 0);
            end
            prev_hold = bus.r_valid && !bus.r_ready;
            prev_data = bus.r_data;
            if (bus.a_valid && bus.a_ready) sent++;
            if (bus.done) finished = 1;
            step();
            cyc++;
        end
        bus.a_valid = 1'b0; bus.r_ready = 1'b1;
        chk("job_finished", finished, 1);
        chk("handshakes", sent, len);
        chk("results", res_cnt - res0, len);
        chk("done_once", done_cnt - done0, 1);
        chk("job_idle", bus.busy, 0);
        chk("job_err_count", bus.err_count, 0);
        if (stall_len > 0) chk("stall_seen", stall_used, 1);
    endtask

    initial begin
        int cyc;
        tab[0] = '{8'h10, 8'h30, 8'h02, 8'h04, 24'h004000, 16'h0000, 1'b0, 24'h0040E0, 16'd0};
        tab[1] = '{8'h10, 8'h30, 8'h02, 8'h04, 24'h004000, 16'h0012, 1'b1, 24'h0040F2, 16'd1};
        tab[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 24'hFFFFFF, 16'hFFFF, 1'b0, 24'h02FC00, 16'd0};
        tab[3] = '{8'h01, 8'h00, 8'h80, 8'h7F, 24'h000000, 16'h0000, 1'b0, 24'h000080, 16'd0};
        tab[4] = '{8'h00, 8'h05, 8'h11, 8'h03, 24'h123456, 16'h0001, 1'b0, 24'h123466, 16'd0};

        rst = 1'b1;
        bus.start = 0; bus.vec_len = 0; bus.w_valid = 0; bus.w_data = 0;
        bus.a_valid = 0; bus.a_data = 0; bus.psum_init = 0;
        bus.err_col = 0; bus.err_sig_col = 0; bus.r_ready = 0;
        step(); step();
        chk("rst_ctrl", {bus.busy, bus.done, bus.w_ready, bus.a_ready, bus.weight_load, bus.r_valid}, 0);
        chk("rst_weight_bus", bus.weight_bus, 0);
        chk("rst_act_bus", bus.act_bus, 0);
        chk("rst_psum_inj", bus.psum_inj, 0);
        chk("rst_err_inj", bus.err_inj, 0);
        chk("rst_r_data", bus.r_data, 0);
        chk("rst_err_count", bus.err_count, 0);
        chk("rst_array_en", bus.array_en, 1);
        rst = 1'b0;
        step();
        mon_en = 1;

        for (int i = 0; i < 5; i++) run_single(tab[i]);

        // Ignored starts: zero length in IDLE, any start while busy
        bus.start = 1'b1; bus.vec_len = 8'd0;
        step();
        bus.start = 1'b0;
        chk("len0_ignored", {bus.busy, bus.w_ready}, 2'b00);
        start_job(8'd1);
        bus.start = 1'b1; bus.vec_len = 8'd5;
        step();
        bus.start = 1'b0;
        chk("busy_start_ignored", {bus.busy, bus.w_ready}, 2'b11);
        bus.err_col = 16'd0;
        load_w(16'h0201);
        bus.a_valid = 1'b1; bus.a_data = 16'h0101; bus.psum_init = 24'h000010;
        step();
        chk("len_kept_a_ready", {bus.busy, bus.a_ready}, 2'b10);
        bus.a_valid = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < 20) begin step(); cyc++; end
        chk("len_kept_done", bus.done, 1);
        step();

        run_job(4, 1'b1, 0, 100, 100);
        run_job(6, 1'b0, 5, 100, 100);
        for (int i = 0; i < 8; i++)
            run_job($urandom_range(1, 8), 1'b0, 0, $urandom_range(30, 100), $urandom_range(30, 100));

        // Reset in the middle of a stream
        mon_en = 0;
        bus.err_col = 16'd0; bus.r_ready = 1'b1;
        start_job(8'd4);
        load_w(16'hA55A);
        bus.a_valid = 1'b1; bus.a_data = 16'h0302; bus.psum_init = 24'h000100;
        step(); step();
        bus.a_valid = 1'b0; bus.err_sig_col = 2'b01;
        step();
        bus.err_sig_col = 2'b00;
        chk("pre_rst_busy", bus.busy, 1);
        chk("pre_rst_err_count", bus.err_count, 1);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_ctrl", {bus.busy, bus.done, bus.w_ready, bus.a_ready, bus.weight_load, bus.r_valid}, 0);
        chk("mid_rst_weight_bus", bus.weight_bus, 0);
        chk("mid_rst_act_bus", bus.act_bus, 0);
        chk("mid_rst_psum_inj", bus.psum_inj, 0);
        chk("mid_rst_r_data", bus.r_data, 0);
        chk("mid_rst_err_count", bus.err_count, 0);
        step();
        rst = 1'b0;
        sb.delete();
        step();
        chk("post_rst_idle", bus.busy, 0);
        mon_en = 1;
        run_single(tab[0]);

        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
